adc_spi_responder: RTL and testbench
====================================

Name: adc_spi_responder

Overview:
- Synthesizable SPI responder that emulates the serial ADC on the far end of the MAIN acquisition path.
- Answers MAIN's convst/sclk initiator with WIDTH-bit conversion codes, MSB first on miso.
- Codes come from an internal ramp or an external code_in port, so code-density histograms can be checked on hardware without a real ADC.
- Sits in the top level in place of the ADC model, on the same clk domain as MAIN.

Parameters:
- WIDTH, 10, code width in bits
- T_POWER_UP, 150, clk cycles after reset before convst is honoured
- T_CONVERSION, 230, clk cycles from accepted convst rising edge to data ready
- STEP, 1, ramp increment per completed conversion

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-high reset
- convst  input  1  conversion start from MAIN; rising edge starts a conversion
- sclk  input  1  serial clock from MAIN; asynchronous to clk
- sel_ext  input  1  0 = ramp code, 1 = code_in
- code_in  input  WIDTH  external code, sampled at end of conversion
- miso  output  1  serial data to MAIN
- busy  output  1  high in CONVERT
- conv_done  output  1  one-cycle pulse when a code is latched
- code_out  output  WIDTH  last latched code

Behaviour:
- Reset (async, rst=1) values:
  - miso=0, busy=0, conv_done=0, code_out=0.
  - Ramp register = 0, shift register = 0, bit counter = 0.
  - State = POWERUP, power-up timer = 0.
- Input synchronization:
  - convst and sclk each pass through a 2-FF synchronizer, then a registered edge detector.
  - Internal edge events occur 3 clk cycles after the pin edge.
  - Legal sclk high and low times are at least 4 clk cycles each. Narrower pulses give undefined results.
- State machine (POWERUP, IDLE, CONVERT, SHIFT):
  - POWERUP: counts T_POWER_UP cycles, then goes to IDLE. convst edges during POWERUP are ignored and never queued.
  - IDLE: a convst rising event loads the conversion timer and moves to CONVERT. busy=1 in the same cycle the state changes.
  - CONVERT:
    - The timer counts T_CONVERSION cycles.
    - On expiry, the code is latched into the shift register and code_out. The code is code_in if sel_ext=1, else the ramp value.
    - On the same cycle: conv_done pulses, busy drops, miso = code MSB, state goes to SHIFT, bit counter = WIDTH-1.
    - convst and sclk events during CONVERT are ignored.
  - SHIFT:
    - Each sclk falling event shifts left by one; miso = next bit. MSB is already on miso, so MAIN samples on sclk rising.
    - After the falling event that consumes bit 0 (WIDTH falling events in total), miso=0 and state returns to IDLE.
    - sclk rising events do not change state.
    - A convst rising event aborts the shift, sets miso=0 and enters CONVERT. That conversion still advances the ramp.
- Ramp:
  - After each latch with sel_ext=0, ramp <= ramp + STEP, wrapping modulo 2^WIDTH (1023 → 0 at defaults).
  - The ramp does not advance when sel_ext=1.
- Simultaneous events:
  - If the conversion timer expires in the same cycle as a convst event, the latch completes and the convst is dropped.
  - A convst event and an sclk falling event in the same SHIFT cycle resolve as abort (convst wins).
- Reset mid-operation: all state clears immediately and asynchronously; the POWERUP delay is re-applied on release.
- No output is combinational from inputs; miso is registered.

Test Plan:
- Power-up gating: release rst, pulse convst at cycle 50 → busy stays 0 and miso stays 0. Pulse convst at cycle 200 → busy rises 3 cycles after the pin edge and stays high 230 cycles.
- Ramp readout: sel_ext=0, three conversions each followed by 10 sclk periods (8 clk high / 8 clk low) → MAIN-side shift captures 0x000, 0x001, 0x002. code_out matches and conv_done pulses once per conversion.
- External code: sel_ext=1, code_in=10'h2A5 → bits 1,0,1,0,1,0,0,1,0,1 appear on miso in order. miso=0 after the 10th falling edge. Ramp is unchanged.
- Wrap-around: force 1024 conversions with STEP=1 → the 1025th code reads 0x000.
- Abort: convst rising after 4 sclk falling edges in SHIFT → miso=0 and busy=1 within 3 cycles. The next full readout returns the incremented ramp value.
- Async reset mid-CONVERT: assert rst at timer=100 → all outputs 0 in the same timestep. The first code after re-power-up is 0x000.

Source files
------------

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI responder standing in for the serial ADC on the MAIN
// acquisition path. After a power-up delay it accepts a convst rising edge and
// waits out a conversion time. It then latches a WIDTH-bit code and shifts it
// out MSB first on miso, one bit per sclk falling edge. The code comes from an
// internal ramp or from code_in, so code-density histograms can be exercised
// without a real converter.
//
// Ports:
//   clk       system clock (same domain as MAIN)
//   rst       asynchronous active-high reset
//   convst    conversion start, rising edge starts a conversion (async pin)
//   sclk      serial clock from MAIN (async pin), data advances on falling edge
//   sel_ext   0 = ramp code, 1 = code_in
//   code_in   external code, sampled when the conversion ends
//   miso      registered serial data out
//   busy      high while converting
//   conv_done one-cycle pulse when a code is latched
//   code_out  last latched code
module adc_spi_responder #(
  parameter int unsigned WIDTH        = 10,
  parameter int unsigned T_POWER_UP   = 150,
  parameter int unsigned T_CONVERSION = 230,
  parameter int unsigned STEP         = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             convst,
  input  logic             sclk,
  input  logic             sel_ext,
  input  logic [WIDTH-1:0] code_in,
  output logic             miso,
  output logic             busy,
  output logic             conv_done,
  output logic [WIDTH-1:0] code_out
);

  localparam int unsigned PuW = $clog2(T_POWER_UP + 1);
  localparam int unsigned CvW = $clog2(T_CONVERSION + 1);
  localparam int unsigned BcW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [PuW-1:0]   PuLast = PuW'(T_POWER_UP - 1);
  // Loading T_CONVERSION-1 and latching on zero keeps busy high T_CONVERSION cycles.
  localparam logic [CvW-1:0]   CvLoad = CvW'(T_CONVERSION - 1);
  localparam logic [BcW-1:0]   BcLoad = BcW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] RampStep = WIDTH'(STEP);

  typedef enum logic [1:0] {StPowerUp, StIdle, StConvert, StShift} state_e;

  state_e           state_q, state_d;
  logic [PuW-1:0]   pu_cnt_q, pu_cnt_d;
  logic [CvW-1:0]   cv_cnt_q, cv_cnt_d;
  logic [BcW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] ramp_q, ramp_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic             miso_q, miso_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // [0],[1] form the 2-FF synchronizer, [2] is the edge-detect delay stage.
  // Events are therefore decided from registers and act on the third clk edge.
  logic [2:0]       convst_sync_q, convst_sync_d;
  logic [2:0]       sclk_sync_q, sclk_sync_d;
  logic             convst_rise;
  logic             sclk_fall;
  logic [WIDTH-1:0] latch_code;

  always_comb begin
    convst_sync_d = {convst_sync_q[1:0], convst};
    sclk_sync_d   = {sclk_sync_q[1:0], sclk};
    convst_rise   = convst_sync_q[1] & ~convst_sync_q[2];
    sclk_fall     = ~sclk_sync_q[1] & sclk_sync_q[2];
    latch_code    = sel_ext ? code_in : ramp_q;
  end

  always_comb begin
    state_d   = state_q;
    pu_cnt_d  = pu_cnt_q;
    cv_cnt_d  = cv_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ramp_d    = ramp_q;
    code_d    = code_q;
    miso_d    = miso_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StPowerUp: begin
        // convst is not looked at here, so early edges are simply lost.
        if (pu_cnt_q == PuLast) begin
          state_d = StIdle;
        end else begin
          pu_cnt_d = pu_cnt_q + 1'b1;
        end
      end

      StIdle: begin
        if (convst_rise) begin
          state_d  = StConvert;
          cv_cnt_d = CvLoad;
          busy_d   = 1'b1;
        end
      end

      StConvert: begin
        // All convst/sclk events are ignored, including one coinciding with expiry.
        if (cv_cnt_q == '0) begin
          shift_d   = latch_code;
          code_d    = latch_code;
          miso_d    = latch_code[WIDTH-1];
          bit_cnt_d = BcLoad;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = StShift;
          if (!sel_ext) begin
            ramp_d = ramp_q + RampStep;
          end
        end else begin
          cv_cnt_d = cv_cnt_q - 1'b1;
        end
      end

      StShift: begin
        // convst has priority over a coincident sclk falling edge.
        if (convst_rise) begin
          miso_d   = 1'b0;
          state_d  = StConvert;
          cv_cnt_d = CvLoad;
          busy_d   = 1'b1;
        end else if (sclk_fall) begin
          if (bit_cnt_q == '0) begin
            miso_d  = 1'b0;
            state_d = StIdle;
          end else begin
            shift_d   = shift_q << 1;
            miso_d    = shift_q[WIDTH-2];
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end

      default: state_d = StPowerUp;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StPowerUp;
      pu_cnt_q      <= '0;
      cv_cnt_q      <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      ramp_q        <= '0;
      code_q        <= '0;
      miso_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      convst_sync_q <= '0;
      sclk_sync_q   <= '0;
    end else begin
      state_q       <= state_d;
      pu_cnt_q      <= pu_cnt_d;
      cv_cnt_q      <= cv_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      ramp_q        <= ramp_d;
      code_q        <= code_d;
      miso_q        <= miso_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      convst_sync_q <= convst_sync_d;
      sclk_sync_q   <= sclk_sync_d;
    end
  end

  assign miso      = miso_q;
  assign busy      = busy_q;
  assign conv_done = done_q;
  assign code_out  = code_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: a default-parameter instance covers power-up
// gating, ramp and external readout, abort and reset; a fast-timing instance
// covers ramp wrap-around. Expected codes are queued when a conversion is
// started and checked against code_out on each conv_done pulse.
module tb_adc_spi_responder;

  logic       clk = 1'b0;
  logic       rst, convst, sclk, sel_ext;
  logic [9:0] code_in;
  logic       miso, busy, conv_done;
  logic [9:0] code_out;

  logic       rst2, convst2, sclk2;
  logic       miso2, busy2, conv_done2;
  logic [9:0] code_out2;
  logic       sel_ext2 = 1'b0;
  logic [9:0] code_in2 = 10'h000;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int n_done2  = 0;

  logic [9:0] exp_q[$];
  logic [9:0] exp2_q[$];
  logic [9:0] ramp_m  = 10'h000;
  logic [9:0] ramp2_m = 10'h000;

  always #5 clk = ~clk;

  adc_spi_responder dut (
    .clk       (clk),
    .rst       (rst),
    .convst    (convst),
    .sclk      (sclk),
    .sel_ext   (sel_ext),
    .code_in   (code_in),
    .miso      (miso),
    .busy      (busy),
    .conv_done (conv_done),
    .code_out  (code_out)
  );

  adc_spi_responder #(
    .WIDTH        (10),
    .T_POWER_UP   (8),
    .T_CONVERSION (4),
    .STEP         (1)
  ) dut_wrap (
    .clk       (clk),
    .rst       (rst2),
    .convst    (convst2),
    .sclk      (sclk2),
    .sel_ext   (sel_ext2),
    .code_in   (code_in2),
    .miso      (miso2),
    .busy      (busy2),
    .conv_done (conv_done2),
    .code_out  (code_out2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Scoreboards: one expected code is queued per started conversion.
  always @(negedge clk) begin
    if (conv_done) begin
      n_done++;
      check("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) check("code_out", code_out, exp_q.pop_front());
    end
    if (conv_done2) begin
      n_done2++;
      check("sb2_depth", exp2_q.size(), 1);
      if (exp2_q.size() > 0) check("code_out2", code_out2, exp2_q.pop_front());
    end
  end

  // Starts a conversion from posedge+1, records busy latency/length and miso at rise.
  // Returns at the negedge after busy falls, with the MSB on miso.
  task automatic do_conv(output int rise, output int len, output logic miso_at_rise);
    rise = -1;
    len = 0;
    miso_at_rise = 1'b1;
    convst = 1'b1;
    if (sel_ext) exp_q.push_back(code_in);
    else begin
      exp_q.push_back(ramp_m);
      ramp_m = ramp_m + 10'd1;
    end
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk);
      #1;
      if (i == 4) convst = 1'b0;
      @(negedge clk);
      if (busy) begin
        if (rise < 0) begin
          rise = i;
          miso_at_rise = miso;
        end
        len++;
      end else if (rise >= 0) begin
        break;
      end
    end
    convst = 1'b0;
  endtask

  // MAIN-side capture: sample miso on sclk rising, 8 clk high / 8 clk low.
  task automatic read_word(input int n, output logic [9:0] w);
    w = '0;
    for (int b = 0; b < n; b++) begin
      sclk = 1'b1;
      w = {w[8:0], miso};
      tick(8);
      sclk = 1'b0;
      tick(8);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, len;
    logic m, any_busy, any_miso;
    logic [9:0] w;
    logic [9:0] ramp_exp[3];

    rst = 1'b1; convst = 1'b0; sclk = 1'b0; sel_ext = 1'b0; code_in = 10'h000;
    rst2 = 1'b1; convst2 = 1'b0; sclk2 = 1'b0;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_miso", miso, 0);
    check("rst_done", conv_done, 0);
    check("rst_code", code_out, 0);

    // Power-up gating: convst at cycle 50 must be ignored.
    rst = 1'b0;
    while (cyc < 50) tick(1);
    convst = 1'b1;
    any_busy = 1'b0;
    any_miso = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 4) convst = 1'b0;
      @(negedge clk);
      any_busy |= busy;
      any_miso |= miso;
    end
    check("pu_busy", any_busy, 0);
    check("pu_miso", any_miso, 0);

    // Ramp readout: three conversions read 0, 1, 2.
    while (cyc < 200) tick(1);
    ramp_exp[0] = 10'h000; ramp_exp[1] = 10'h001; ramp_exp[2] = 10'h002;
    for (int k = 0; k < 3; k++) begin
      do_conv(rise, len, m);
      check("busy_rise", rise, 3);
      check("busy_len", len, 230);
      read_word(10, w);
      check("ramp_word", w, ramp_exp[k]);
      check("miso_end", miso, 0);
    end

    // External code, ramp must not advance.
    sel_ext = 1'b1;
    code_in = 10'h2A5;
    do_conv(rise, len, m);
    check("ext_msb", miso, 1);
    read_word(10, w);
    check("ext_word", w, 10'h2A5);
    check("ext_miso_end", miso, 0);
    sel_ext = 1'b0;
    code_in = 10'h000;

    // Abort after 4 falling edges; the aborted code 3 still advances the ramp.
    do_conv(rise, len, m);
    read_word(4, w);
    check("abort_partial", w, 10'h000);
    do_conv(rise, len, m);
    check("abort_busy_rise", rise, 3);
    check("abort_miso", m, 0);
    read_word(10, w);
    check("abort_next_word", w, 10'h004);
    check("done_count", n_done, 6);

    // Async reset mid-conversion.
    convst = 1'b1;
    tick(4);
    convst = 1'b0;
    tick(100);
    check("busy_pre_rst", busy, 1);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_miso", miso, 0);
    check("arst_done", conv_done, 0);
    check("arst_code", code_out, 0);
    ramp_m = 10'h000;
    tick(3);
    rst = 1'b0;
    while (cyc < 160) tick(1);
    do_conv(rise, len, m);
    check("post_rst_rise", rise, 3);
    read_word(10, w);
    check("post_rst_word", w, 10'h000);
    check("done_count2", n_done, 7);

    // Wrap-around on the fast instance: 1024 conversions, then the 1025th reads 0.
    rst2 = 1'b0;
    tick(12);
    for (int k = 0; k < 1025; k++) begin
      convst2 = 1'b1;
      exp2_q.push_back(ramp2_m);
      ramp2_m = ramp2_m + 10'd1;
      tick(3);
      convst2 = 1'b0;
      tick(10);
    end
    w = '0;
    for (int b = 0; b < 10; b++) begin
      sclk2 = 1'b1;
      w = {w[8:0], miso2};
      tick(8);
      sclk2 = 1'b0;
      tick(8);
    end
    check("wrap_word", w, 10'h000);
    check("wrap_miso_end", miso2, 0);
    check("wrap_done_count", n_done2, 1025);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
